// File: rtl/bp_ctrl_unit_pkg.sv
// Shared opcode constants, counter type and PC-to-index helper for the branch predictor.
package bp_ctrl_unit_pkg;

  localparam int unsigned BP_CNT_W    = 2;
  localparam int unsigned BP_PC_MAX_W = 64;

  // Base opcodes shared with the ID-stage decoder
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] JAL      = 7'b1101111;

  typedef logic [BP_CNT_W-1:0] bp_cnt_t;

  // Word address of a PC; callers truncate to their own index width
  function automatic logic [BP_PC_MAX_W-1:0] bp_pc_word(input logic [BP_PC_MAX_W-1:0] pc);
    return pc >> 2;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// One BHT entry: saturating up/down counter with enable and synchronous reset.
module bp_sat_counter #(
  parameter int unsigned CNT_W    = 2,
  parameter int unsigned INIT_CNT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt;

  // Count toward the resolved direction, holding at either rail
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= CNT_W'(INIT_CNT);
    end else if (i_en) begin
      if (i_inc && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (!i_inc && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/bp_ctrl_unit.sv
// ID-stage branch predictor: direct-mapped BHT, EX-stage training, flush and statistics.
module bp_ctrl_unit
  import bp_ctrl_unit_pkg::*;
#(
  parameter int unsigned PC_W     = 32,
  parameter int unsigned IDX_W    = 6,
  parameter int unsigned CNT_W    = BP_CNT_W,
  parameter int unsigned INIT_CNT = 1,
  parameter int unsigned STAT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              id_valid,
  input  logic [6:0]        id_opcode,
  input  logic [PC_W-1:0]   id_pc,
  output logic              bp_id,
  input  logic              ex_valid,
  input  logic              ex_is_cond,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic              ex_taken,
  input  logic              ex_pred,
  output logic              flush,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispred
);

  localparam int unsigned NUM_ENT = 2 ** IDX_W;

  logic [IDX_W-1:0]  w_id_idx;
  logic [IDX_W-1:0]  w_ex_idx;
  logic              w_update;
  logic              w_mispred;
  logic [CNT_W-1:0]  w_cnt [NUM_ENT];
  logic [STAT_W-1:0] r_stat_branches;
  logic [STAT_W-1:0] r_stat_mispred;

  assign w_id_idx  = IDX_W'(bp_pc_word(BP_PC_MAX_W'(id_pc)));
  assign w_ex_idx  = IDX_W'(bp_pc_word(BP_PC_MAX_W'(ex_pc)));
  assign w_update  = ex_valid & ex_is_cond;
  assign w_mispred = w_update & (ex_taken != ex_pred);

  // Counter table; only the entry selected by the EX PC is trained
  for (genvar g = 0; g < NUM_ENT; g++) begin : g_bht
    bp_sat_counter #(
      .CNT_W    (CNT_W),
      .INIT_CNT (INIT_CNT)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_update && (w_ex_idx == IDX_W'(g))),
      .i_inc (ex_taken),
      .o_cnt (w_cnt[g])
    );
  end

  // Opcode-based prediction; conditional branches read the table without bypass
  always_comb begin
    bp_id = 1'b0;
    if (rst_n && !stall && id_valid) begin
      case (id_opcode)
        OP_B:    bp_id = w_cnt[w_id_idx][CNT_W-1];
        JAL:     bp_id = 1'b1;
        default: bp_id = 1'b0;
      endcase
    end
  end

  assign flush = rst_n & w_mispred;

  // Resolution and mispredict counters, wrapping naturally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_branches <= '0;
      r_stat_mispred  <= '0;
    end else begin
      if (w_update) begin
        r_stat_branches <= r_stat_branches + STAT_W'(1);
      end
      if (w_mispred) begin
        r_stat_mispred <= r_stat_mispred + STAT_W'(1);
      end
    end
  end

  assign stat_branches = r_stat_branches;
  assign stat_mispred  = r_stat_mispred;

endmodule

// File: tb/tb_bp_ctrl_unit.sv
// Directed bench for bp_ctrl_unit with default parameters.
module tb_bp_ctrl_unit;
  import bp_ctrl_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        id_valid;
  logic [6:0]  id_opcode;
  logic [31:0] id_pc;
  logic        bp_id;
  logic        ex_valid;
  logic        ex_is_cond;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic        ex_pred;
  logic        flush;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;

  int n_chk  = 0;
  int n_pass = 0;

  bp_ctrl_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .id_valid      (id_valid),
    .id_opcode     (id_opcode),
    .id_pc         (id_pc),
    .bp_id         (bp_id),
    .ex_valid      (ex_valid),
    .ex_is_cond    (ex_is_cond),
    .ex_pc         (ex_pc),
    .ex_taken      (ex_taken),
    .ex_pred       (ex_pred),
    .flush         (flush),
    .stat_branches (stat_branches),
    .stat_mispred  (stat_mispred)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input string tag, input logic [6:0] op, input logic [31:0] pc,
                        input logic exp);
    id_valid  = 1'b1;
    id_opcode = op;
    id_pc     = pc;
    #1;
    chk(tag, 32'(bp_id), 32'(exp));
  endtask

  // One-cycle EX resolution; flush checked before the edge
  task automatic resolve(input string tag, input logic [31:0] pc, input logic tk,
                         input logic pr, input logic exp_flush);
    ex_valid   = 1'b1;
    ex_is_cond = 1'b1;
    ex_pc      = pc;
    ex_taken   = tk;
    ex_pred    = pr;
    #1;
    chk(tag, 32'(flush), 32'(exp_flush));
    tick();
    ex_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; id_valid = 1'b0; id_opcode = '0; id_pc = '0;
    ex_valid = 1'b0; ex_is_cond = 1'b0; ex_pc = '0; ex_taken = 1'b0; ex_pred = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_branches", stat_branches, 32'd0);
    chk("rst_mispred", stat_mispred, 32'd0);
    for (int i = 0; i < 64; i++) begin
      lookup($sformatf("rst_entry%0d", i), OP_B, 32'(i * 4), 1'b0);
    end

    // Training at 0x40: 1->2 (mispredicted), 2->3
    resolve("train_flush", 32'h40, 1'b1, 1'b0, 1'b1);
    chk("train_br1", stat_branches, 32'd1);
    chk("train_mp1", stat_mispred, 32'd1);
    resolve("train_noflush", 32'h40, 1'b1, 1'b1, 1'b0);
    chk("train_br2", stat_branches, 32'd2);
    chk("train_mp2", stat_mispred, 32'd1);
    lookup("train_taken", OP_B, 32'h40, 1'b1);
    lookup("alias_taken", OP_B, 32'h140, 1'b1);
    // 3->2->1->0, then hold at 0, then 0->1
    resolve("nt1", 32'h40, 1'b0, 1'b1, 1'b1);
    resolve("nt2", 32'h40, 1'b0, 1'b1, 1'b1);
    resolve("nt3", 32'h40, 1'b0, 1'b1, 1'b1);
    lookup("nt_pred0", OP_B, 32'h40, 1'b0);
    resolve("nt_sat", 32'h40, 1'b0, 1'b0, 1'b0);
    resolve("tk_from0", 32'h40, 1'b1, 1'b1, 1'b0);
    lookup("sat0_hold", OP_B, 32'h40, 1'b0);
    chk("nt_br", stat_branches, 32'd7);
    chk("nt_mp", stat_mispred, 32'd4);

    // Saturation at 0x80: 1,2,3,3,3 then 2 then 1
    for (int i = 0; i < 5; i++) resolve($sformatf("sat_tk%0d", i), 32'h80, 1'b1, 1'b1, 1'b0);
    resolve("sat_nt1", 32'h80, 1'b0, 1'b1, 1'b1);
    lookup("sat_still_taken", OP_B, 32'h80, 1'b1);
    resolve("sat_nt2", 32'h80, 1'b0, 1'b1, 1'b1);
    lookup("sat_now_nt", OP_B, 32'h80, 1'b0);
    chk("sat_br", stat_branches, 32'd14);
    chk("sat_mp", stat_mispred, 32'd6);

    // Opcode decode and stall gating
    lookup("op_jal", JAL, 32'h0, 1'b1);
    lookup("op_jalr", JALR, 32'h0, 1'b0);
    lookup("op_r", OP_R, 32'h0, 1'b0);
    stall = 1'b1;
    lookup("stall_jal", JAL, 32'h0, 1'b0);
    stall = 1'b0;
    id_valid = 1'b0;
    #1;
    chk("novalid_jal", 32'(bp_id), 32'd0);

    // Training continues under stall: 0xC0 goes 1->2->3
    stall = 1'b1;
    lookup("stall_opb", OP_B, 32'hC0, 1'b0);
    resolve("stall_up1", 32'hC0, 1'b1, 1'b1, 1'b0);
    resolve("stall_up2", 32'hC0, 1'b1, 1'b1, 1'b0);
    stall = 1'b0;
    lookup("stall_trained", OP_B, 32'hC0, 1'b1);

    // Non-conditional EX instructions leave the table and counters alone
    ex_valid = 1'b1; ex_is_cond = 1'b0; ex_pc = 32'h100; ex_taken = 1'b1; ex_pred = 1'b0;
    #1;
    chk("noncond_flush", 32'(flush), 32'd0);
    tick(); tick();
    ex_valid = 1'b0;
    lookup("noncond_entry", OP_B, 32'h100, 1'b0);
    chk("noncond_br", stat_branches, 32'd16);
    chk("noncond_mp", stat_mispred, 32'd6);

    // Same-cycle lookup and update of 0x40 (counter 1->2), plus aliasing via 0x140
    id_valid = 1'b1; id_opcode = OP_B; id_pc = 32'h40;
    ex_valid = 1'b1; ex_is_cond = 1'b1; ex_pc = 32'h40; ex_taken = 1'b1; ex_pred = 1'b0;
    #1;
    chk("coll_old", 32'(bp_id), 32'd0);
    chk("coll_flush", 32'(flush), 32'd1);
    tick();
    ex_valid = 1'b0;
    #1;
    chk("coll_new", 32'(bp_id), 32'd1);
    lookup("coll_alias", OP_B, 32'h140, 1'b1);
    chk("coll_br", stat_branches, 32'd17);
    chk("coll_mp", stat_mispred, 32'd7);

    // Reset mid-operation discards the pending update
    rst_n = 1'b0;
    ex_valid = 1'b1; ex_is_cond = 1'b1; ex_pc = 32'h80; ex_taken = 1'b1; ex_pred = 1'b0;
    id_opcode = JAL;
    #1;
    chk("rst_flush0", 32'(flush), 32'd0);
    chk("rst_bp0", 32'(bp_id), 32'd0);
    tick();
    rst_n = 1'b1;
    ex_valid = 1'b0;
    lookup("rst_0x80", OP_B, 32'h80, 1'b0);
    lookup("rst_0x40", OP_B, 32'h40, 1'b0);
    lookup("rst_0xC0", OP_B, 32'hC0, 1'b0);
    chk("rst2_br", stat_branches, 32'd0);
    chk("rst2_mp", stat_mispred, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
